// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per req/ack handshake
// and holds it for decode until the core retires it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        PCSrc,
  input  logic [31:0] immExt,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] next_pc;
  logic        retire;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = misaligned_q;
    retire        = instr_valid_q & instrReady;
    next_pc       = PCSrc ? (instr_pc_q + immExt) : (instr_pc_q + 32'd4);

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imemAck) begin
          instr_d       = imemRdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = REQ;
          end else begin
            // A misaligned target is fatal: pc keeps the faulting instruction's fetch address.
            misaligned_d = 1'b1;
            state_d      = FAULT;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // All outputs come straight from flops; none depends combinationally on an input.
  assign imemReq    = (state_q == REQ);
  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign instrPC    = instr_pc_q;
  assign instrValid = instr_valid_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, fetch, sequential and
// branch retire, stall, delayed ack, misaligned fault, async reset and PC wrap.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic        instrValid;
  logic        instrReady;
  logic        PCSrc;
  logic [31:0] immExt;
  logic        misaligned;

  int vectors;
  int miscompares;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemAck   (imemAck),
    .imemRdata (imemRdata),
    .instr     (instr),
    .instrPC   (instrPC),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .PCSrc     (PCSrc),
    .immExt    (immExt),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag, input logic [31:0] pc, input logic [31:0] word);
    check({tag, "_valid"}, {31'd0, instrValid}, 32'd1);
    check({tag, "_instr"}, instr, word);
    check({tag, "_pc"}, instrPC, pc);
    check({tag, "_req"}, {31'd0, imemReq}, 32'd0);
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, imemReq}, 32'd1);
    check({tag, "_addr"}, imemAddr, addr);
    check({tag, "_valid"}, {31'd0, instrValid}, 32'd0);
    check({tag, "_nop"}, instr, NOP);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstN        = 1'b0;
    imemAck     = 1'b0;
    imemRdata   = 32'h0;
    instrReady  = 1'b0;
    PCSrc       = 1'b0;
    immExt      = 32'h0;

    // Reset values.
    step();
    step();
    check("rst_req", {31'd0, imemReq}, 32'd0);
    check("rst_addr", imemAddr, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_ipc", instrPC, 32'h0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);

    // Release with ack tied high: REQ after first edge, HOLD after second.
    rstN      = 1'b1;
    imemAck   = 1'b1;
    imemRdata = 32'h0050_0093;
    step();
    check_req("first_req", 32'h0);
    step();
    check_hold("first_hold", 32'h0, 32'h0050_0093);

    // Branch from 0 to 0x10.
    instrReady = 1'b1;
    PCSrc      = 1'b1;
    immExt     = 32'h10;
    step();
    check_req("br10_req", 32'h10);
    instrReady = 1'b0;
    imemRdata  = 32'h1111_1111;
    step();
    check_hold("at10", 32'h10, 32'h1111_1111);

    // Sequential retire at 0x10 ignores immExt.
    instrReady = 1'b1;
    PCSrc      = 1'b0;
    immExt     = 32'h40;
    step();
    check_req("seq14_req", 32'h14);
    instrReady = 1'b0;
    imemRdata  = 32'h2222_2222;
    step();
    check_hold("at14", 32'h14, 32'h2222_2222);

    // Branch back to 0x10 (imm -4).
    instrReady = 1'b1;
    PCSrc      = 1'b1;
    immExt     = 32'hFFFF_FFFC;
    step();
    check_req("back10_req", 32'h10);
    instrReady = 1'b0;
    imemRdata  = 32'h3333_3333;
    step();
    check_hold("again10", 32'h10, 32'h3333_3333);

    // Stall 3 cycles with spurious ack and changing rdata/PCSrc/immExt.
    PCSrc     = 1'b1;
    immExt    = 32'hFFFF_FFF8;
    imemAck   = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_hold("stall", 32'h10, 32'h3333_3333);
    end

    // Retire taken branch 0x10 + (-8) = 0x08.
    instrReady = 1'b1;
    step();
    check_req("br08_req", 32'h08);
    instrReady = 1'b0;

    // Ack delayed 4 cycles: request held stable.
    imemAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_req("wait_ack", 32'h08);
    end
    imemAck   = 1'b1;
    imemRdata = 32'h4444_4444;
    step();
    check_hold("at08", 32'h08, 32'h4444_4444);

    // Branch to 0x20, then misaligned branch from there.
    instrReady = 1'b1;
    PCSrc      = 1'b1;
    immExt     = 32'h18;
    step();
    check_req("br20_req", 32'h20);
    instrReady = 1'b0;
    imemRdata  = 32'h5555_5555;
    step();
    check_hold("at20", 32'h20, 32'h5555_5555);
    instrReady = 1'b1;
    immExt     = 32'h6;
    step();
    check("fault_mis", {31'd0, misaligned}, 32'd1);
    check("fault_valid", {31'd0, instrValid}, 32'd0);
    check("fault_req", {31'd0, imemReq}, 32'd0);
    check("fault_instr", instr, NOP);
    check("fault_addr", imemAddr, 32'h20);
    for (int i = 0; i < 2; i++) begin
      step();
      check("fault_stay_req", {31'd0, imemReq}, 32'd0);
      check("fault_stay_mis", {31'd0, misaligned}, 32'd1);
    end

    // Asynchronous reset between edges clears outputs immediately.
    instrReady = 1'b0;
    PCSrc      = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    check("arst_mis", {31'd0, misaligned}, 32'd0);
    check("arst_addr", imemAddr, 32'h0);
    check("arst_ipc", instrPC, 32'h0);
    check("arst_req", {31'd0, imemReq}, 32'd0);
    step();
    rstN      = 1'b1;
    imemRdata = 32'h6666_6666;
    step();
    check_req("restart_req", 32'h0);
    step();
    check_hold("restart_hold", 32'h0, 32'h6666_6666);

    // Branch to 0xFFFFFFFC, then sequential retire wraps to 0.
    instrReady = 1'b1;
    PCSrc      = 1'b1;
    immExt     = 32'hFFFF_FFFC;
    step();
    check_req("top_req", 32'hFFFF_FFFC);
    instrReady = 1'b0;
    imemRdata  = 32'h7777_7777;
    step();
    check_hold("attop", 32'hFFFF_FFFC, 32'h7777_7777);
    instrReady = 1'b1;
    PCSrc      = 1'b0;
    step();
    check_req("wrap_req", 32'h0);
    check("wrap_mis", {31'd0, misaligned}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
